// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - wrapper-side controller for the 2-way 512-set data-cache core
// Single outstanding CPU access; misses write back a dirty victim, refill, install and replay.
module dcache_ctrl #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 128
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [3:0]            cpu_be,
   input  logic [ADDR_W-1:0]     cpu_addr,
   input  logic [31:0]           cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_rvalid,
   output logic [31:0]           cpu_rdata,
   output logic [ADDR_W-1:0]     dc_addr,
   output logic                  dc_r,
   output logic [LINE_W/8-1:0]   dc_wd,
   output logic [LINE_W-1:0]     dc_din,
   input  logic                  dc_hit,
   input  logic                  dc_dirty,
   input  logic [ADDR_W-14:0]    dc_tout,
   input  logic [LINE_W-1:0]     dc_dout,
   output logic                  mem_req,
   output logic                  mem_wr,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [LINE_W-1:0]     mem_wdata,
   input  logic                  mem_ack,
   input  logic                  mem_rvalid,
   input  logic [LINE_W-1:0]     mem_rdata
);
   localparam int TAG_W = ADDR_W - 13;
   localparam int WE_W  = LINE_W / 8;

   typedef enum logic [3:0] {IDLE, LK1, LK2, WB, RD, RDW, FILL, RP0, RP1, RP2} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [3:0]          be_q, be_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [LINE_W-1:0]   wb_buf_q, wb_buf_d;
   logic [LINE_W-1:0]   fill_buf_q, fill_buf_d;
   logic [TAG_W-1:0]    victim_tag_q, victim_tag_d;
   logic                rvalid_q, rvalid_d;
   logic [31:0]         rdata_q, rdata_d;

   logic                issue, respond;
   logic                iss_we;
   logic [3:0]          iss_be;
   logic [ADDR_W-1:0]   iss_addr;
   logic [31:0]         iss_wdata;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         we_q         <= 1'b0;
         be_q         <= '0;
         wdata_q      <= '0;
         wb_buf_q     <= '0;
         fill_buf_q   <= '0;
         victim_tag_q <= '0;
         rvalid_q     <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         we_q         <= we_d;
         be_q         <= be_d;
         wdata_q      <= wdata_d;
         wb_buf_q     <= wb_buf_d;
         fill_buf_q   <= fill_buf_d;
         victim_tag_q <= victim_tag_d;
         rvalid_q     <= rvalid_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      wb_buf_d     = wb_buf_q;
      fill_buf_d   = fill_buf_q;
      victim_tag_d = victim_tag_q;
      rvalid_d     = 1'b0;
      rdata_d      = rdata_q;
      issue        = 1'b0;
      respond      = 1'b0;
      iss_we       = we_q;
      iss_be       = be_q;
      iss_addr     = addr_q;
      iss_wdata    = wdata_q;
      cpu_ready    = 1'b0;
      dc_addr      = '0;
      dc_r         = 1'b0;
      dc_wd        = '0;
      dc_din       = '0;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      case (state_q)
         IDLE: begin
            cpu_ready = 1'b1;
            if (cpu_req) begin
               addr_d    = cpu_addr;
               we_d      = cpu_we;
               be_d      = cpu_be;
               wdata_d   = cpu_wdata;
               issue     = 1'b1;
               iss_we    = cpu_we;
               iss_be    = cpu_be;
               iss_addr  = cpu_addr;
               iss_wdata = cpu_wdata;
               state_d   = LK1;
            end
         end
         LK1: state_d = LK2;
         LK2: begin
            if (dc_hit) begin
               respond = 1'b1;
               state_d = IDLE;
            end else begin
               wb_buf_d     = dc_dout;
               victim_tag_d = dc_tout;
               state_d      = dc_dirty ? WB : RD;
            end
         end
         WB: begin
            mem_req   = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {victim_tag_q, addr_q[12:4], 4'b0000};
            mem_wdata = wb_buf_q;
            if (mem_ack) state_d = RD;
         end
         RD: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[ADDR_W-1:4], 4'b0000};
            if (mem_ack) begin
               if (mem_rvalid) begin
                  fill_buf_d = mem_rdata;
                  state_d    = FILL;
               end else begin
                  state_d = RDW;
               end
            end
         end
         RDW: begin
            if (mem_rvalid) begin
               fill_buf_d = mem_rdata;
               state_d    = FILL;
            end
         end
         FILL: begin
            dc_addr = addr_q;
            dc_wd   = '1;
            dc_din  = fill_buf_q;
            state_d = RP0;
         end
         RP0: begin
            issue   = 1'b1;
            state_d = RP1;
         end
         RP1: state_d = RP2;
         RP2: begin
            // A miss after install means the core lost the line; look it up again.
            if (dc_hit) begin
               respond = 1'b1;
               state_d = IDLE;
            end else begin
               issue   = 1'b1;
               state_d = LK1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         dc_addr = iss_addr;
         if (iss_we) begin
            dc_wd  = WE_W'(iss_be) << {iss_addr[3:2], 2'b00};
            dc_din = {(LINE_W/32){iss_wdata}};
         end else begin
            dc_r = 1'b1;
         end
      end

      if (respond) begin
         rvalid_d = 1'b1;
         rdata_d  = we_q ? 32'h0 : dc_dout[{addr_q[3:2], 5'b00000} +: 32];
      end

      if (!resetn) begin
         cpu_ready = 1'b0;
         dc_addr   = '0;
         dc_r      = 1'b0;
         dc_wd     = '0;
         dc_din    = '0;
         mem_req   = 1'b0;
         mem_wr    = 1'b0;
         mem_addr  = '0;
         mem_wdata = '0;
      end
   end

   assign cpu_rvalid = rvalid_q & resetn;
   assign cpu_rdata  = resetn ? rdata_q : 32'h0;

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl with behavioural core and memory
// Core and memory are modelled here; expected load data comes from an architectural memory model.
module tb_dcache_ctrl;
   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [3:0]    cpu_be = '0;
   logic [31:0]   cpu_addr = '0, cpu_wdata = '0;
   logic          cpu_ready, cpu_rvalid;
   logic [31:0]   cpu_rdata;
   logic [31:0]   dc_addr;
   logic          dc_r;
   logic [15:0]   dc_wd;
   logic [127:0]  dc_din;
   logic          dc_hit, dc_dirty;
   logic [18:0]   dc_tout;
   logic [127:0]  dc_dout;
   logic          mem_req, mem_wr, mem_ack, mem_rvalid;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata, mem_rdata;

   dcache_ctrl #(.ADDR_W(32), .LINE_W(128)) dut (
      .clk(clk), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dc_addr(dc_addr), .dc_r(dc_r), .dc_wd(dc_wd), .dc_din(dc_din),
      .dc_hit(dc_hit), .dc_dirty(dc_dirty), .dc_tout(dc_tout), .dc_dout(dc_dout),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, act, exp);
      end
   endtask

   // Architectural memory: what every load must return.
   logic [31:0] ref_mem [logic [31:0]];
   function automatic logic [31:0] init_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC3A5, a[15:0]};
   endfunction
   function automatic logic [31:0] ref_word(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_word(a);
   endfunction
   function automatic logic [127:0] ref_line(input logic [31:0] la);
      return {ref_word(la + 12), ref_word(la + 8), ref_word(la + 4), ref_word(la)};
   endfunction

   // Backing memory behind the bridge.
   logic [127:0] mem_arr [logic [31:0]];
   function automatic logic [127:0] line_of(input logic [31:0] la);
      if (mem_arr.exists(la)) return mem_arr[la];
      return {init_word(la + 12), init_word(la + 8), init_word(la + 4), init_word(la)};
   endfunction

   int            ack_dly = 1, rv_dly = 3;
   logic          m_busy = 1'b0, m_wr = 1'b0;
   logic [31:0]   m_addr = '0;
   logic [127:0]  m_wdata = '0;
   int            m_cnt = 0;
   logic [32:0]   mem_log [$];
   logic [127:0]  wlog [$];

   assign mem_ack    = m_busy && (m_cnt == ack_dly);
   assign mem_rvalid = m_busy && !m_wr && (m_cnt == rv_dly);
   assign mem_rdata  = mem_rvalid ? line_of(m_addr) : '0;

   always @(posedge clk) begin
      if (!resetn) begin
         m_busy <= 1'b0;
         m_cnt  <= 0;
      end else if (!m_busy) begin
         if (mem_req) begin
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            m_wr    <= mem_wr;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            mem_log.push_back({mem_wr, mem_addr});
            wlog.push_back(mem_wdata);
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_wr && mem_ack) begin
            mem_arr[m_addr] = m_wdata;
            m_busy <= 1'b0;
         end else if (!m_wr && m_cnt >= ack_dly && m_cnt >= rv_dly) begin
            m_busy <= 1'b0;
         end
      end
   end

   // Core model: 2 ways x 512 sets, results two cycles after the command.
   logic [18:0]   ctag [2][512];
   logic          cval [2][512];
   logic          cdty [2][512];
   logic [127:0]  cdat [2][512];
   logic          clru [512];
   logic          s1_hit, s1_dty, s2_hit, s2_dty;
   logic [18:0]   s1_tag, s2_tag;
   logic [127:0]  s1_dat, s2_dat;
   assign dc_hit = s2_hit;
   assign dc_dirty = s2_dty;
   assign dc_tout = s2_tag;
   assign dc_dout = s2_dat;

   always @(posedge clk) begin : core_model
      logic [8:0] st;
      logic [18:0] tg;
      logic h0, h1, hw, vw;
      logic [127:0] ln;
      if (!resetn) begin
         for (int s = 0; s < 512; s++) begin
            cval[0][s] <= 1'b0; cval[1][s] <= 1'b0;
            cdty[0][s] <= 1'b0; cdty[1][s] <= 1'b0;
            clru[s] <= 1'b0;
         end
         s1_hit <= 1'b0; s1_dty <= 1'b0; s1_tag <= '0; s1_dat <= '0;
         s2_hit <= 1'b0; s2_dty <= 1'b0; s2_tag <= '0; s2_dat <= '0;
      end else begin
         s2_hit <= s1_hit; s2_dty <= s1_dty; s2_tag <= s1_tag; s2_dat <= s1_dat;
         s1_hit <= 1'b0; s1_dty <= 1'b0; s1_tag <= '0; s1_dat <= '0;
         if (dc_r || dc_wd != 16'h0) begin
            st = dc_addr[12:4];
            tg = dc_addr[31:13];
            h0 = cval[0][st] && ctag[0][st] == tg;
            h1 = cval[1][st] && ctag[1][st] == tg;
            hw = h1;
            vw = clru[st];
            if (h0 || h1) begin
               s1_hit <= 1'b1; s1_dat <= cdat[hw][st]; s1_dty <= cdty[hw][st]; s1_tag <= ctag[hw][st];
               clru[st] <= ~hw;
               if (dc_wd != 16'h0) begin
                  ln = cdat[hw][st];
                  for (int b = 0; b < 16; b++) if (dc_wd[b]) ln[b*8 +: 8] = dc_din[b*8 +: 8];
                  cdat[hw][st] <= ln;
                  if (dc_wd != 16'hFFFF) cdty[hw][st] <= 1'b1;
               end
            end else begin
               s1_dat <= cdat[vw][st]; s1_dty <= cval[vw][st] && cdty[vw][st]; s1_tag <= ctag[vw][st];
               if (dc_wd == 16'hFFFF) begin
                  cdat[vw][st] <= dc_din; ctag[vw][st] <= tg;
                  cval[vw][st] <= 1'b1; cdty[vw][st] <= 1'b0;
                  clru[st] <= ~vw;
               end
            end
         end
      end
   end

   // Scoreboard and monitors.
   typedef struct packed {logic we; logic [31:0] data; int acc; int lat;} sb_t;
   sb_t           sbq [$];
   int            rv_cnt = 0, fill_cnt = 0, rv_snap = 0;
   logic [31:0]   fill_addr = '0;
   logic [127:0]  fill_din = '0;
   logic          stab_en = 1'b0;
   logic [15:0]   acc_wd = '0;
   logic [127:0]  acc_din = '0;

   initial forever begin
      sb_t e;
      @(negedge clk);
      if (resetn && cpu_rvalid) begin
         rv_cnt++;
         if (sbq.size() == 0) check("rvalid_spurious", 1, 0);
         else begin
            e = sbq.pop_front();
            if (!e.we) check("rdata", cpu_rdata, e.data);
            if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
         end
      end
      if (resetn && dc_wd == 16'hFFFF) begin
         fill_cnt++;
         fill_addr = dc_addr;
         fill_din = dc_din;
      end
      if (stab_en && m_busy && mem_req) check("mem_stable", {mem_wr, mem_addr, mem_wdata}, {m_wr, m_addr, m_wdata});
   end

   task automatic issue_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                            input logic [31:0] wd, input int lat);
      int guard;
      logic [31:0] w, wa;
      sb_t e;
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = we; cpu_be = be; cpu_addr = addr; cpu_wdata = wd;
      #1;
      guard = 0;
      while (!cpu_ready && guard < 50) begin @(negedge clk); #1; guard++; end
      if (!cpu_ready) check("ready_timeout", 0, 1);
      acc_wd = dc_wd;
      acc_din = dc_din;
      wa = {addr[31:2], 2'b00};
      w = ref_word(wa);
      if (we) begin
         for (int b = 0; b < 4; b++) if (be[b]) w[b*8 +: 8] = wd[b*8 +: 8];
         ref_mem[wa] = w;
      end
      e.we = we; e.data = w; e.acc = cyc; e.lat = lat;
      sbq.push_back(e);
      rv_snap = rv_cnt;
      @(negedge clk);
      cpu_req = 1'b0;
   endtask

   task automatic wait_rsp();
      int guard = 0;
      #2;
      while (rv_cnt == rv_snap && guard < 300) begin @(negedge clk); #2; guard++; end
      if (rv_cnt == rv_snap) check("rvalid_timeout", 0, 1);
   endtask

   task automatic do_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input int lat);
      issue_req(we, be, addr, wd, lat);
      wait_rsp();
   endtask

   initial begin
      logic [127:0] l0;
      int f0, r0, guard;
      l0 = 128'h0123456789ABCDEF0123456789ABCDEF;
      mem_arr[32'h1230] = l0;
      for (int i = 0; i < 4; i++) ref_mem[32'h1230 + 4*i] = l0[i*32 +: 32];

      repeat (20) @(negedge clk);
      #1;
      check("rst_ready", cpu_ready, 0);
      check("rst_outs", {mem_req, dc_r, dc_wd, cpu_rvalid}, 0);
      repeat (580) @(negedge clk);
      resetn = 1'b1;
      #1;
      check("idle_ready", cpu_ready, 1);

      // Cold load miss
      mem_log.delete(); wlog.delete(); f0 = fill_cnt;
      do_req(1'b0, 4'h0, 32'h0000_1230, 32'h0, -1);
      check("t1_memlog_n", mem_log.size(), 1);
      if (mem_log.size() > 0) check("t1_rd", mem_log[0], {1'b0, 32'h0000_1230});
      check("t1_fills", fill_cnt - f0, 1);
      check("t1_fill_din", fill_din, l0);
      check("t1_fill_addr", fill_addr, 32'h0000_1230);

      // Load hit
      mem_log.delete(); f0 = fill_cnt;
      do_req(1'b0, 4'h0, 32'h0000_1234, 32'h0, 3);
      check("t2_no_mem", mem_log.size(), 0);
      check("t2_no_fill", fill_cnt - f0, 0);

      // Store hit then read back
      do_req(1'b1, 4'b0011, 32'h0000_1238, 32'hAAAA_BBBB, 3);
      check("t3_wd", acc_wd, 16'h0300);
      check("t3_din", acc_din, {4{32'hAAAA_BBBB}});
      do_req(1'b0, 4'h0, 32'h0000_1238, 32'h0, 3);
      check("t3_ref", ref_word(32'h0000_1238), 32'h89AB_BBBB);

      // Dirty eviction in set 0x123, zero-latency memory
      ack_dly = 0; rv_dly = 0;
      do_req(1'b0, 4'h0, 32'h0000_3230, 32'h0, -1);
      mem_log.delete(); wlog.delete();
      do_req(1'b0, 4'h0, 32'h0000_5230, 32'h0, -1);
      check("t4_memlog_n", mem_log.size(), 2);
      if (mem_log.size() == 2) begin
         check("t4_wb", mem_log[0], {1'b1, 32'h0000_1230});
         check("t4_wb_data", wlog[0], ref_line(32'h0000_1230));
         check("t4_rd", mem_log[1], {1'b0, 32'h0000_5230});
      end
      check("t4_fill_addr", fill_addr, 32'h0000_5230);
      mem_log.delete();
      do_req(1'b0, 4'h0, 32'h0000_1238, 32'h0, -1);
      if (mem_log.size() > 0) check("t4_refetch", mem_log[0], {1'b0, 32'h0000_1230});
      else check("t4_refetch_n", 0, 1);

      // Slow memory
      ack_dly = 7; rv_dly = 10;
      mem_log.delete(); r0 = rv_cnt; stab_en = 1'b1;
      do_req(1'b0, 4'h0, 32'h0000_9004, 32'h0, -1);
      stab_en = 1'b0;
      repeat (6) @(negedge clk);
      check("t5_one_rvalid", rv_cnt - r0, 1);
      check("t5_memlog_n", mem_log.size(), 1);
      if (mem_log.size() > 0) check("t5_rd", mem_log[0], {1'b0, 32'h0000_9000});

      // Store miss: fill then replay the store
      ack_dly = 1; rv_dly = 3;
      do_req(1'b1, 4'b1100, 32'h0000_D00C, 32'h1234_5678, -1);
      do_req(1'b0, 4'h0, 32'h0000_D00C, 32'h0, 3);

      // Reset while waiting for refill data
      ack_dly = 1; rv_dly = 30;
      mem_log.delete();
      issue_req(1'b0, 4'h0, 32'h0000_B000, 32'h0, -1);
      guard = 0;
      while (mem_log.size() == 0 && guard < 50) begin @(negedge clk); guard++; end
      check("t6_started", mem_log.size(), 1);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      sbq.delete();
      f0 = fill_cnt; r0 = rv_cnt;
      @(negedge clk);
      #1;
      check("t6_memreq_drop", mem_req, 0);
      check("t6_no_fill", dc_wd, 0);
      check("t6_ready_low", cpu_ready, 0);
      repeat (600) @(negedge clk);
      check("t6_fills_held", fill_cnt - f0, 0);
      check("t6_rvalid_held", rv_cnt - r0, 0);
      resetn = 1'b1;
      #1;
      check("t6_idle", {cpu_ready, mem_req}, 2'b10);
      ack_dly = 1; rv_dly = 3;
      mem_log.delete(); f0 = fill_cnt;
      do_req(1'b0, 4'h0, 32'h0000_1234, 32'h0, -1);
      check("t6_cold_n", mem_log.size(), 1);
      if (mem_log.size() > 0) check("t6_cold_rd", mem_log[0], {1'b0, 32'h0000_1230});
      check("t6_cold_fill", fill_cnt - f0, 1);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1);
   end
endmodule
